// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for instruction fetch and load/store requesters
module mem_port_arbiter #(
    parameter int AW       = 61,
    parameter int DW       = 64,
    parameter int LAT      = 1,
    parameter int MAX_SKIP = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int SW = (MAX_SKIP > 0) ? $clog2(MAX_SKIP + 1) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [SW-1:0] SKIP_MAX = SW'(MAX_SKIP);
    localparam logic [CW-1:0] LAT_LOAD = CW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          owner_d;
    logic          we_q;
    logic [SW-1:0] skip_cnt;
    logic [CW-1:0] lat_cnt;
    logic          d_win;

    // D wins unless fetch has already been passed over MAX_SKIP times in a row
    always_comb begin
        d_win = d_req && (!i_req || (skip_cnt < SKIP_MAX));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            we_q      <= 1'b0;
            skip_cnt  <= '0;
            lat_cnt   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        if (d_win) begin
                            owner_d   <= 1'b1;
                            we_q      <= d_we;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            if (i_req) begin
                                skip_cnt <= skip_cnt + SW'(1);
                            end
                        end else begin
                            owner_d  <= 1'b0;
                            we_q     <= 1'b0;
                            mem_we   <= 1'b0;
                            mem_addr <= i_addr;
                            skip_cnt <= '0;
                        end
                        mem_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Read data is on mem_rdata during the last WAIT cycle
                    if (lat_cnt == '0) begin
                        if (owner_d) begin
                            d_ack <= 1'b1;
                            if (!we_q) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end
                RESP: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT0 = 1;
    localparam int MAX0 = 3;
    localparam int LAT1 = 3;
    localparam int MAX1 = 0;

    logic        clk;
    logic        rst_n;
    logic        mem_init;

    logic        i_req, i_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
    logic [60:0] i_addr, d_addr, mem_addr;
    logic [63:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

    logic        i2_req, i2_ack, d2_req, d2_we, d2_ack, mem_en2, mem_we2, busy2;
    logic [60:0] i2_addr, d2_addr, mem_addr2;
    logic [63:0] i2_rdata, d2_wdata, d2_rdata, mem_wdata2, mem_rdata2;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state (transaction level)
    int          s;
    int          next_free;
    int          skip;
    bit          g_d, g_we;
    logic [60:0] g_addr;
    logic [63:0] g_wdata, g_rdata, exp_i, exp_d;
    logic [7:0]  gbits;

    // requester intent (what a well-behaved requester presents)
    bit          ti_req, td_req, td_we;
    logic [60:0] ti_addr, td_addr;
    logic [63:0] td_wdata;

    mem_port_arbiter #(.AW(61), .DW(64), .LAT(LAT0), .MAX_SKIP(MAX0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(61), .DW(64), .LAT(LAT1), .MAX_SKIP(MAX1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i2_req), .i_addr(i2_addr), .i_ack(i2_ack), .i_rdata(i2_rdata),
        .d_req(d2_req), .d_we(d2_we), .d_addr(d2_addr), .d_wdata(d2_wdata),
        .d_ack(d2_ack), .d_rdata(d2_rdata),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] pat(input int i);
        return (i == 0) ? 64'h7C221A14_38600001 : {32'hA5A50000 + i[31:0], ~i[31:0]};
    endfunction

    function automatic logic [60:0] rand61();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[60:0];
    endfunction

    function automatic logic [60:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? rand61() : 61'($urandom_range(0, 15));
    endfunction

    // memory models: fixed-latency reads, data only valid in the due cycle
    logic [63:0] mem0 [64];
    logic [63:0] p0_d [LAT0];
    logic [LAT0-1:0] p0_v;
    logic [63:0] mem1 [64];
    logic [63:0] p1_d [LAT1];
    logic [LAT1-1:0] p1_v;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem0[i] <= pat(i);
        end else if (mem_en && mem_we) begin
            mem0[mem_addr[5:0]] <= mem_wdata;
        end
        p0_v[0] <= mem_en && !mem_we;
        p0_d[0] <= mem0[mem_addr[5:0]];
        for (int i = 1; i < LAT0; i++) begin
            p0_v[i] <= p0_v[i-1];
            p0_d[i] <= p0_d[i-1];
        end
    end
    assign mem_rdata = p0_v[LAT0-1] ? p0_d[LAT0-1] : 64'hDEADBEEF_DEADBEEF;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem1[i] <= pat(i);
        end else if (mem_en2 && mem_we2) begin
            mem1[mem_addr2[5:0]] <= mem_wdata2;
        end
        p1_v[0] <= mem_en2 && !mem_we2;
        p1_d[0] <= mem1[mem_addr2[5:0]];
        for (int i = 1; i < LAT1; i++) begin
            p1_v[i] <= p1_v[i-1];
            p1_d[i] <= p1_d[i-1];
        end
    end
    assign mem_rdata2 = p1_v[LAT1-1] ? p1_d[LAT1-1] : 64'hDEADBEEF_DEADBEEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic new_i();
        ti_addr = rand_addr();
    endtask

    task automatic new_d();
        td_we    = 1'($urandom_range(0, 1));
        td_addr  = rand_addr();
        td_wdata = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ti_req = 1'b0;
        td_req = 1'b0;
        i_req  = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_mem_en", 64'(mem_en), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_i_ack", 64'(i_ack), 64'(0));
        check("rst_d_ack", 64'(d_ack), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", mem_wdata, 64'(0));
        check("rst_i_rdata", i_rdata, 64'(0));
        check("rst_d_rdata", d_rdata, 64'(0));
        rst_n = 1'b1;
    endtask

    task automatic run0(input int ncyc, input bit contend, input bit stop_at_wait);
        int k;
        int ng;
        bit in_busy, ack_now, idle_now, dwin;
        k = 0; ng = 0; s = -1; next_free = 0; skip = 0;
        exp_i = '0; exp_d = '0; gbits = '0;
        forever begin
            if (stop_at_wait && k >= ncyc && s >= 0 && k == s + LAT0 + 1) return;
            if (!stop_at_wait && k >= ncyc) return;
            if (k > ncyc + 500) begin
                check("wait_timeout", 64'(1), 64'(0));
                return;
            end
            in_busy = (s >= 0) && (k >= s + 1) && (k <= s + LAT0 + 2);
            ack_now = (s >= 0) && (k == s + LAT0 + 2);
            check("busy", 64'(busy), 64'(in_busy));
            check("mem_en", 64'(mem_en), 64'((s >= 0) && (k == s + 1)));
            if ((s >= 0) && (k == s + 1)) begin
                check("mem_we", 64'(mem_we), 64'(g_we));
                if (g_we) check("mem_wdata", mem_wdata, g_wdata);
            end
            if (in_busy) check("mem_addr", 64'(mem_addr), 64'(g_addr));
            check("i_ack", 64'(i_ack), 64'(ack_now && !g_d));
            check("d_ack", 64'(d_ack), 64'(ack_now && g_d));
            if (contend && ng < 8 && (i_ack || d_ack)) begin
                gbits = {gbits[6:0], d_ack};
                ng++;
            end
            if (ack_now) begin
                if (!g_d) exp_i = g_rdata;
                else if (!g_we) exp_d = g_rdata;
            end
            check("i_rdata", i_rdata, exp_i);
            check("d_rdata", d_rdata, exp_d);

            if (ack_now && !g_d) begin
                ti_req = contend ? 1'b1 : 1'($urandom_range(0, 1));
                new_i();
            end else if (!ti_req && k > 0) begin
                ti_req = contend || ($urandom_range(0, 2) == 0);
                new_i();
            end
            if (ack_now && g_d) begin
                td_req = contend ? 1'b1 : 1'($urandom_range(0, 1));
                new_d();
            end else if (!td_req && k > 0) begin
                td_req = contend || ($urandom_range(0, 2) == 0);
                new_d();
            end

            idle_now = (k >= next_free);
            if (idle_now && (ti_req || td_req)) begin
                dwin = td_req && (!ti_req || skip < MAX0);
                if (dwin && ti_req) skip++;
                else if (!dwin) skip = 0;
                s       = k;
                g_d     = dwin;
                g_we    = dwin && td_we;
                g_addr  = dwin ? td_addr : ti_addr;
                g_wdata = td_wdata;
                g_rdata = g_we ? 64'h0 : mem0[g_addr[5:0]];
                next_free = k + LAT0 + 3;
            end

            i_req = ti_req;
            d_req = td_req;
            // inputs are ignored while busy, so scramble them there
            if (!idle_now && $urandom_range(0, 1) == 1) begin
                i_addr  = rand61();
                d_addr  = rand61();
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = {$urandom, $urandom};
            end else begin
                i_addr  = ti_addr;
                d_addr  = td_addr;
                d_we    = td_we;
                d_wdata = td_wdata;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic acc1(input string tag, input bit we, input logic [60:0] a,
                        input logic [63:0] wd, input logic [63:0] exp_rd);
        int en_k, ack_k;
        en_k = -1; ack_k = -1;
        d2_req = 1'b1; d2_we = we; d2_addr = a; d2_wdata = wd;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_en2 && en_k < 0) begin
                en_k = k;
                check({tag, "_we"}, 64'(mem_we2), 64'(we));
                check({tag, "_addr"}, 64'(mem_addr2), 64'(a));
                check({tag, "_busy"}, 64'(busy2), 64'(1));
                if (we) check({tag, "_wdata"}, mem_wdata2, wd);
            end
            if (d2_ack && ack_k < 0) begin
                ack_k = k;
                d2_req = 1'b0;
                if (!we) check({tag, "_rdata"}, d2_rdata, exp_rd);
            end
        end
        check({tag, "_en_cycle"}, 64'(en_k), 64'(1));
        check({tag, "_ack_cycle"}, 64'(ack_k), 64'(LAT1 + 2));
    endtask

    initial begin
        int ik, dk;
        rst_n = 1'b0; mem_init = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        i2_req = 0; i2_addr = '0; d2_req = 0; d2_we = 0; d2_addr = '0; d2_wdata = '0;
        ti_req = 0; td_req = 0; td_we = 0; ti_addr = '0; td_addr = '0; td_wdata = '0;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        do_reset();

        // first access: lone fetch of address 0, then random traffic, end in WAIT
        ti_req = 1'b1; ti_addr = '0; td_req = 1'b0;
        run0(300, 1'b0, 1'b1);
        do_reset();

        // both requesters saturating
        ti_req = 1'b1; td_req = 1'b1; new_i(); new_d();
        run0(44, 1'b1, 1'b0);
        check("grant_order", 64'(gbits), 64'(8'b1110_1110));
        do_reset();

        ti_req = 1'b0; td_req = 1'b0;
        run0(400, 1'b0, 1'b0);
        do_reset();

        acc1("st10", 1'b1, 61'h10, 64'h0123456789ABCDEF, 64'h0);
        acc1("ld10", 1'b0, 61'h10, 64'h0, 64'h0123456789ABCDEF);

        // MAX_SKIP=0 tie: fetch first, then data
        ik = -1; dk = -1;
        i2_req = 1'b1; i2_addr = 61'h5;
        d2_req = 1'b1; d2_we = 1'b0; d2_addr = 61'h10;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (i2_ack && d2_ack) check("tie_overlap", 64'(1), 64'(0));
            if (i2_ack && ik < 0) begin
                ik = k; i2_req = 1'b0;
                check("tie_i_rdata", i2_rdata, pat(5));
            end
            if (d2_ack && dk < 0) begin
                dk = k; d2_req = 1'b0;
                check("tie_d_rdata", d2_rdata, 64'h0123456789ABCDEF);
            end
        end
        check("tie_i_cycle", 64'(ik), 64'(LAT1 + 2));
        check("tie_d_cycle", 64'(dk), 64'(2 * LAT1 + 5));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
